serialload: RTL and testbench
=============================

SERIALLOAD -- requirements
Module: serialload

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, master data word width; multiple of 8, 8..64.
REQ-002 SHALL have parameter FIFO_DEPTH, default 64, word FIFO depth; power of 2, >=4.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, master address width.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_a  in  3  control register index
- s_d  in  32  control write data
- s_we  in  1  control write strobe
- s_spo  out  32  control read data, combinational from s_a
- s_ready  out  1  constant 1
- m_req  out  1  bus request
- m_gnt  in  1  bus grant
- m_a  out  ADDR_WIDTH  write address
- m_d  out  DATA_WIDTH  write data
- m_we  out  1  write strobe
- m_rd  out  1  constant 0
- m_ready  in  1  slave ready for a new access
- uart_data  in  8  received byte
- uart_ready  in  1  one-cycle pulse, uart_data valid

Function
REQ-005 SHALL map registers: 0 CTRL write (bit0 start, bit1 mode 0=hex 1=binary, bit2 abort); 1 BASE (RW); 2 LEN bytes (RW, binary mode only); 3 STATUS read {29'b0, overflow, done, busy}; 4 WORDS read, words written since start; 5 CSUM read, 32-bit wrapping sum of accepted payload bytes/nibble-pairs.
REQ-006 SHALL implement FSM IDLE -> REQ -> RUN -> DRAIN -> IDLE.
REQ-007 IDLE: start write latches mode, clears WORDS, CSUM, done, overflow, FIFO, assembler; loads m_a from BASE; enters REQ with m_req=1.
REQ-008 Start write while busy SHALL be ignored.
REQ-009 REQ: stays until m_gnt=1, then RUN; UART bytes before grant SHALL be ignored.
REQ-010 Hex mode: chars 0-9, a-f, A-F SHALL shift one nibble into the assembler MSB-first; other chars except 0x20 ignored.
REQ-011 Hex mode: after DATA_WIDTH/4 nibbles the word SHALL be pushed; 0x20 ends reception, partial nibbles discarded.
REQ-012 Binary mode: every byte accepted, placed little-endian (first byte in [7:0]); push after DATA_WIDTH/8 bytes.
REQ-013 Binary mode: reception ends when accepted bytes equal LEN; nonzero partial word zero-padded in upper bytes and pushed; LEN=0 ends immediately.
REQ-014 CSUM adds each accepted binary byte, or each completed hex byte (two nibbles), zero-extended.
REQ-015 Push when FIFO full SHALL drop the word and set sticky overflow; no stall of UART side.
REQ-016 Push and write-issue in same cycle SHALL both occur; FIFO count unchanged.
REQ-017 Write issue: in RUN or DRAIN, FIFO non-empty and m_ready=1 -> m_we=1 one cycle, m_d=FIFO head, head popped; next cycle m_a += DATA_WIDTH/8, WORDS += 1, m_we=0; at most one write per two cycles.
REQ-018 m_a SHALL wrap modulo 2^ADDR_WIDTH.
REQ-019 End of reception -> DRAIN; DRAIN with FIFO empty and no write in flight -> IDLE, m_req=0, done=1.
REQ-020 busy SHALL equal 1 in REQ, RUN, DRAIN.
REQ-021 Abort in any state SHALL next cycle force IDLE, m_req=0, m_we=0, flush FIFO and assembler, done=0; BASE, LEN, WORDS, CSUM, overflow kept.
REQ-022 Abort and start in the same write: abort wins, start ignored.
REQ-023 BASE write while busy SHALL update BASE only, not m_a.

Reset
REQ-024 rst SHALL set FSM IDLE, m_req=0, m_we=0, m_a=0, m_d=0, BASE=0, LEN=0, WORDS=0, CSUM=0, status=0, FIFO empty, assembler cleared; rst mid-transfer behaves identically, partial data lost.

Verification
REQ-025 Hex, DATA_WIDTH=32, BASE=0x1000, send "12345678 " -> one write m_a=0x1000 m_d=0x12345678; done=1, WORDS=1, CSUM=0x114, m_req=0.
REQ-026 Binary, LEN=6, BASE=0x2000, bytes 01..06 -> writes 0x04030201 @0x2000, 0x00000605 @0x2004; WORDS=2, CSUM=0x15.
REQ-027 Hex with "12_34xx5678 " -> noise ignored, single write 0x12345678.
REQ-028 FIFO_DEPTH=4, m_ready held 0, 6 words binary -> overflow=1, first 4 words written after m_ready=1, WORDS=4.
REQ-029 Abort during RUN after 1 word -> m_req=0 next cycle, busy=0, done=0, WORDS=1; subsequent start works normally.
REQ-030 BASE=0xFFFFFFFC, binary LEN=8 -> writes at 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/serialload.sv
// serialload: receives a data stream from a UART byte interface, assembles it into
// DATA_WIDTH words (ASCII hex or raw binary), buffers the words in a FIFO and writes them
// to consecutive addresses on a simple master bus starting at BASE.
//
// Ports:
//   clk, rst           single rising-edge clock, synchronous active-high reset
//   s_a/s_d/s_we       control register index, write data, write strobe
//   s_spo              control read data, combinational from s_a
//   s_ready            always 1
//   m_req/m_gnt        bus request (held while busy) / grant
//   m_a/m_d/m_we       write address, write data, one-cycle write strobe
//   m_rd               always 0 (write-only master)
//   m_ready            slave can accept a new access
//   uart_data/ready    received byte, one-cycle valid pulse
//
// Registers: 0 CTRL (W: bit0 start, bit1 mode 0=hex 1=binary, bit2 abort), 1 BASE, 2 LEN,
// 3 STATUS {overflow, done, busy}, 4 WORDS, 5 CSUM.
module serialload #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            s_a,
  input  logic [31:0]           s_d,
  input  logic                  s_we,
  output logic [31:0]           s_spo,
  output logic                  s_ready,
  output logic                  m_req,
  input  logic                  m_gnt,
  output logic [ADDR_WIDTH-1:0] m_a,
  output logic [DATA_WIDTH-1:0] m_d,
  output logic                  m_we,
  output logic                  m_rd,
  input  logic                  m_ready,
  input  logic [7:0]            uart_data,
  input  logic                  uart_ready
);

  localparam int unsigned Bytes    = DATA_WIDTH / 8;
  localparam int unsigned Nibs     = DATA_WIDTH / 4;
  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam logic [4:0]  LastByte = 5'(Bytes - 1);
  localparam logic [4:0]  LastNib  = 5'(Nibs - 1);
  localparam logic [CntW-1:0]       FifoFull = CntW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(Bytes);

  typedef enum logic [1:0] {StIdle, StReq, StRun, StDrain} state_e;

  state_e                state_q, state_d;
  logic                  mode_q;
  logic [31:0]           base_q, len_q, words_q;
  logic [31:0]           csum_q, csum_d;
  logic [31:0]           byte_cnt_q, byte_cnt_d;
  logic                  done_q, ovf_q, done_set;
  logic [DATA_WIDTH-1:0] asm_q, asm_d, bin_word, push_word;
  logic [4:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] m_a_q;
  logic [DATA_WIDTH-1:0] m_d_q;
  logic                  m_we_q;
  logic                  push, push_ok, issue;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  fifo_empty, fifo_full, fifo_flush;

  logic       ctrl_wr, start_cmd, abort_cmd, start_go, busy;
  logic       is_hex;
  logic [3:0] nib;

  assign ctrl_wr   = s_we && (s_a == 3'd0);
  assign abort_cmd = ctrl_wr && s_d[2];
  // Abort takes priority over a start carried in the same write.
  assign start_cmd = ctrl_wr && s_d[0] && !s_d[2];
  assign start_go  = (state_q == StIdle) && start_cmd;
  assign busy      = (state_q != StIdle);

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FifoFull);
  assign fifo_flush = abort_cmd || start_go;
  assign push_ok    = push && !fifo_full;
  // One write in flight at a time: the cycle after a strobe is spent advancing m_a.
  assign issue = ((state_q == StRun) || (state_q == StDrain)) && !fifo_empty && m_ready &&
                 !m_we_q && !abort_cmd;

  assign s_ready = 1'b1;
  assign m_rd    = 1'b0;
  assign m_req   = busy;
  assign m_a     = m_a_q;
  assign m_d     = m_d_q;
  assign m_we    = m_we_q;

  always_comb begin
    is_hex = 1'b1;
    nib    = 4'h0;
    if (uart_data >= 8'h30 && uart_data <= 8'h39) begin
      nib = uart_data[3:0];
    end else if ((uart_data >= 8'h61 && uart_data <= 8'h66) ||
                 (uart_data >= 8'h41 && uart_data <= 8'h46)) begin
      nib = uart_data[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

  // Binary bytes land little-endian at the current byte slot.
  always_comb begin
    bin_word = asm_q;
    for (int b = 0; b < int'(Bytes); b++) begin
      if (cnt_q == 5'(b)) bin_word[b*8 +: 8] = uart_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    asm_d      = asm_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    push       = 1'b0;
    push_word  = asm_q;
    done_set   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_cmd) begin
          state_d    = StReq;
          asm_d      = '0;
          cnt_d      = '0;
          byte_cnt_d = '0;
          csum_d     = '0;
        end
      end
      StReq: begin
        if (m_gnt) state_d = StRun;
      end
      StRun: begin
        if (!mode_q) begin
          if (uart_ready) begin
            if (is_hex) begin
              asm_d = {asm_q[DATA_WIDTH-5:0], nib};
              // Second nibble of a pair completes a byte for the checksum.
              if (cnt_q[0]) csum_d = csum_q + {24'd0, asm_q[3:0], nib};
              if (cnt_q == LastNib) begin
                push      = 1'b1;
                push_word = {asm_q[DATA_WIDTH-5:0], nib};
                asm_d     = '0;
                cnt_d     = '0;
              end else begin
                cnt_d = cnt_q + 5'd1;
              end
            end else if (uart_data == 8'h20) begin
              state_d = StDrain;
              asm_d   = '0;
              cnt_d   = '0;
            end
          end
        end else if (byte_cnt_q == len_q) begin
          state_d = StDrain;
        end else if (uart_ready) begin
          asm_d      = bin_word;
          csum_d     = csum_q + {24'd0, uart_data};
          byte_cnt_d = byte_cnt_q + 32'd1;
          if (cnt_q == LastByte || byte_cnt_d == len_q) begin
            push      = 1'b1;
            push_word = bin_word;
            asm_d     = '0;
            cnt_d     = '0;
            if (byte_cnt_d == len_q) state_d = StDrain;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      StDrain: begin
        if (fifo_empty && !m_we_q) begin
          state_d  = StIdle;
          done_set = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort_cmd) begin
      state_d    = StIdle;
      asm_d      = '0;
      cnt_d      = '0;
      csum_d     = csum_q;
      byte_cnt_d = byte_cnt_q;
      push       = 1'b0;
      done_set   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      words_q    <= '0;
      csum_q     <= '0;
      byte_cnt_q <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      asm_q      <= '0;
      cnt_q      <= '0;
      m_a_q      <= '0;
      m_d_q      <= '0;
      m_we_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      asm_q      <= asm_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      if (s_we && s_a == 3'd1) base_q <= s_d;
      if (s_we && s_a == 3'd2) len_q <= s_d;
      if (start_go) mode_q <= s_d[1];
      if (start_go || abort_cmd) done_q <= 1'b0;
      else if (done_set)         done_q <= 1'b1;
      if (start_go)                  ovf_q <= 1'b0;
      else if (push && fifo_full)    ovf_q <= 1'b1;
      m_we_q <= issue;
      if (issue) m_d_q <= mem_q[rd_ptr_q];
      // A strobe already on the bus still completes its bookkeeping, even under abort.
      if (start_go)    m_a_q <= ADDR_WIDTH'(base_q);
      else if (m_we_q) m_a_q <= m_a_q + AddrStep;
      if (start_go)    words_q <= '0;
      else if (m_we_q) words_q <= words_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || fifo_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (issue)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(push_ok) - CntW'(issue);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  always_comb begin
    case (s_a)
      3'd1:    s_spo = base_q;
      3'd2:    s_spo = len_q;
      3'd3:    s_spo = {29'd0, ovf_q, done_q, busy};
      3'd4:    s_spo = words_q;
      3'd5:    s_spo = csum_q;
      default: s_spo = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_serialload.sv
// Self-checking bench for serialload: a table of complete transfers plus hand-written
// sequences for overflow, abort, busy-time writes, pre-grant bytes and reset.
module tb_serialload;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  s_a = '0;
  logic [31:0] s_d = '0;
  logic        s_we = 1'b0;
  logic [31:0] s_spo;
  logic        s_ready;
  logic        m_req;
  logic        m_gnt = 1'b0;
  logic [31:0] m_a;
  logic [31:0] m_d;
  logic        m_we;
  logic        m_rd;
  logic        m_ready = 1'b1;
  logic [7:0]  uart_data = '0;
  logic        uart_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [31:0] cap_a [$];
  logic [31:0] cap_d [$];

  always #5 clk = ~clk;

  serialload #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .s_a(s_a), .s_d(s_d), .s_we(s_we), .s_spo(s_spo),
    .s_ready(s_ready), .m_req(m_req), .m_gnt(m_gnt), .m_a(m_a), .m_d(m_d), .m_we(m_we),
    .m_rd(m_rd), .m_ready(m_ready), .uart_data(uart_data), .uart_ready(uart_ready)
  );

  always @(negedge clk) begin
    if (m_we) begin
      cap_a.push_back(m_a);
      cap_d.push_back(m_d);
    end
  end

  typedef struct packed {
    logic         mode;
    logic [31:0]  base;
    logic [31:0]  len;
    logic [7:0]   nb;
    logic [127:0] bytes;
    logic [7:0]   nw;
    logic [31:0]  wa0, wd0, wa1, wd1;
    logic [31:0]  words;
    logic [31:0]  csum;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [127:0] pack_str(input string s);
    logic [127:0] r = '0;
    for (int i = 0; i < s.len(); i++) r[i*8 +: 8] = s[i];
    return r;
  endfunction

  function automatic logic [127:0] seq_bytes(input logic [7:0] first, input int n);
    logic [127:0] r = '0;
    for (int i = 0; i < n; i++) r[i*8 +: 8] = first + 8'(i);
    return r;
  endfunction

  function automatic vec_t mk(input logic mode, input logic [31:0] base, input logic [31:0] len,
                              input int nb, input logic [127:0] bytes, input int nw,
                              input logic [31:0] wa0, input logic [31:0] wd0,
                              input logic [31:0] wa1, input logic [31:0] wd1,
                              input logic [31:0] words, input logic [31:0] csum);
    vec_t v;
    v.mode = mode; v.base = base; v.len = len; v.nb = 8'(nb); v.bytes = bytes;
    v.nw = 8'(nw); v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.words = words; v.csum = csum;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    s_a = a; s_d = d; s_we = 1'b1;
    @(negedge clk);
    s_we = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
    s_a = a;
    #1;
    d = s_spo;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_data = b; uart_ready = 1'b1;
    @(negedge clk);
    uart_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (m_req && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, " idle"}, 64'(m_req), 64'd0);
  endtask

  task automatic check_regs(input string name, input logic [31:0] st, input logic [31:0] words,
                            input logic [31:0] csum);
    logic [31:0] r;
    reg_rd(3'd3, r); check({name, " status"}, 64'(r), 64'(st));
    reg_rd(3'd4, r); check({name, " words"}, 64'(r), 64'(words));
    reg_rd(3'd5, r); check({name, " csum"}, 64'(r), 64'(csum));
  endtask

  initial begin
    logic [31:0] r;
    vec_t v;
    string nm;

    vecs[0] = mk(1'b0, 32'h1000, 32'd0, 9, pack_str("12345678 "), 1,
                 32'h1000, 32'h12345678, 32'h0, 32'h0, 32'd1, 32'h114);
    vecs[1] = mk(1'b1, 32'h2000, 32'd6, 6, seq_bytes(8'h01, 6), 2,
                 32'h2000, 32'h04030201, 32'h2004, 32'h00000605, 32'd2, 32'h15);
    vecs[2] = mk(1'b0, 32'h3000, 32'd0, 12, pack_str("12_34xx5678 "), 1,
                 32'h3000, 32'h12345678, 32'h0, 32'h0, 32'd1, 32'h114);
    vecs[3] = mk(1'b1, 32'hFFFFFFFC, 32'd8, 8, seq_bytes(8'h11, 8), 2,
                 32'hFFFFFFFC, 32'h14131211, 32'h00000000, 32'h18171615, 32'd2, 32'hA4);
    vecs[4] = mk(1'b1, 32'h4000, 32'd0, 0, '0, 0,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'd0, 32'h0);
    vecs[5] = mk(1'b0, 32'h5000, 32'd0, 10, pack_str("abCDef01 9"), 1,
                 32'h5000, 32'hABCDEF01, 32'h0, 32'h0, 32'd1, 32'h268);
    vecs[6] = mk(1'b0, 32'h6000, 32'd0, 5, pack_str("1234 "), 0,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'd0, 32'h46);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset m_req", 64'(m_req), 64'd0);
    check("reset m_we", 64'(m_we), 64'd0);
    check("reset m_a", 64'(m_a), 64'd0);
    check("reset m_rd", 64'(m_rd), 64'd0);
    check("reset s_ready", 64'(s_ready), 64'd1);
    check_regs("reset", 32'd0, 32'd0, 32'd0);

    // Table of complete transfers with grant and slave ready held high.
    m_gnt = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      nm = $sformatf("v%0d", i);
      cap_a.delete(); cap_d.delete();
      reg_wr(3'd1, v.base);
      reg_wr(3'd2, v.len);
      reg_wr(3'd0, {30'd0, v.mode, 1'b1});
      for (int b = 0; b < int'(v.nb); b++) send_byte(v.bytes[b*8 +: 8]);
      wait_idle(nm, 200);
      check({nm, " nwrites"}, 64'(cap_a.size()), 64'(v.nw));
      if (cap_a.size() > 0 && v.nw > 0) begin
        check({nm, " wa0"}, 64'(cap_a[0]), 64'(v.wa0));
        check({nm, " wd0"}, 64'(cap_d[0]), 64'(v.wd0));
      end
      if (cap_a.size() > 1 && v.nw > 1) begin
        check({nm, " wa1"}, 64'(cap_a[1]), 64'(v.wa1));
        check({nm, " wd1"}, 64'(cap_d[1]), 64'(v.wd1));
      end
      check_regs(nm, 32'b010, v.words, v.csum);
    end

    // Overflow: 6 words into a 4-deep FIFO while the slave stalls.
    cap_a.delete(); cap_d.delete();
    m_ready = 1'b0;
    reg_wr(3'd1, 32'h5000);
    reg_wr(3'd2, 32'd24);
    reg_wr(3'd0, 32'h3);
    for (int b = 0; b < 24; b++) send_byte(8'(b + 1));
    check_regs("ovf stalled", 32'b101, 32'd0, 32'd300);
    m_ready = 1'b1;
    wait_idle("ovf", 200);
    check("ovf nwrites", 64'(cap_a.size()), 64'd4);
    for (int k = 0; k < 4 && k < cap_a.size(); k++) begin
      check($sformatf("ovf wa%0d", k), 64'(cap_a[k]), 64'(32'h5000 + 32'(4 * k)));
      check($sformatf("ovf wd%0d", k), 64'(cap_d[k]),
            64'({8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)}));
    end
    check_regs("ovf end", 32'b110, 32'd4, 32'd300);

    // Abort mid-RUN after one word plus a partial word.
    cap_a.delete(); cap_d.delete();
    reg_wr(3'd1, 32'h6000);
    reg_wr(3'd2, 32'd16);
    reg_wr(3'd0, 32'h3);
    for (int b = 0; b < 4; b++) send_byte(8'(b + 1));
    repeat (3) @(negedge clk);
    send_byte(8'h05);
    send_byte(8'h06);
    reg_wr(3'd0, 32'h4);
    check("abort m_req", 64'(m_req), 64'd0);
    check("abort m_we", 64'(m_we), 64'd0);
    check_regs("abort", 32'b000, 32'd1, 32'h15);
    check("abort nwrites", 64'(cap_a.size()), 64'd1);
    // Restart works from a clean assembler.
    cap_a.delete(); cap_d.delete();
    reg_wr(3'd1, 32'h6100);
    reg_wr(3'd0, 32'h1);
    send_str("CAFEBABE ");
    wait_idle("post-abort", 200);
    check("post-abort nwrites", 64'(cap_a.size()), 64'd1);
    if (cap_a.size() > 0) begin
      check("post-abort wa", 64'(cap_a[0]), 64'h6100);
      check("post-abort wd", 64'(cap_d[0]), 64'hCAFEBABE);
    end
    check_regs("post-abort", 32'b010, 32'd1, 32'h340);

    // Abort and start together in IDLE: start ignored, done cleared.
    reg_wr(3'd0, 32'h5);
    check_regs("abort+start", 32'b000, 32'd1, 32'h340);

    // Pre-grant bytes, start while busy, BASE write while busy.
    cap_a.delete(); cap_d.delete();
    m_gnt = 1'b0;
    reg_wr(3'd1, 32'h7000);
    reg_wr(3'd0, 32'h1);
    send_str("9999");
    reg_wr(3'd1, 32'h8000);
    reg_wr(3'd0, 32'h3);
    check("req holds m_req", 64'(m_req), 64'd1);
    m_gnt = 1'b1;
    @(negedge clk);
    send_str("00000001 ");
    wait_idle("busy-wr", 200);
    check("busy-wr nwrites", 64'(cap_a.size()), 64'd1);
    if (cap_a.size() > 0) begin
      check("busy-wr wa", 64'(cap_a[0]), 64'h7000);
      check("busy-wr wd", 64'(cap_d[0]), 64'h00000001);
    end
    reg_rd(3'd1, r); check("busy-wr base", 64'(r), 64'h8000);
    check_regs("busy-wr", 32'b010, 32'd1, 32'h1);

    // Reset mid-transfer with data queued and a partial word assembled.
    m_ready = 1'b0;
    reg_wr(3'd1, 32'h9000);
    reg_wr(3'd2, 32'd8);
    reg_wr(3'd0, 32'h3);
    for (int b = 0; b < 5; b++) send_byte(8'(b + 1));
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst2 m_req", 64'(m_req), 64'd0);
    check("rst2 m_we", 64'(m_we), 64'd0);
    check("rst2 m_a", 64'(m_a), 64'd0);
    check("rst2 m_d", 64'(m_d), 64'd0);
    reg_rd(3'd1, r); check("rst2 base", 64'(r), 64'd0);
    reg_rd(3'd2, r); check("rst2 len", 64'(r), 64'd0);
    check_regs("rst2", 32'b000, 32'd0, 32'd0);
    cap_a.delete(); cap_d.delete();
    m_ready = 1'b1;
    reg_wr(3'd1, 32'hA000);
    reg_wr(3'd2, 32'd4);
    reg_wr(3'd0, 32'h3);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    wait_idle("rst2 after", 200);
    check("rst2 nwrites", 64'(cap_a.size()), 64'd1);
    if (cap_a.size() > 0) check("rst2 wd", 64'(cap_d[0]), 64'hDDCCBBAA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
